// File: rtl/sec_counter_bcd.sv
// Seconds timebase and two-digit BCD counter (00-59) with run/stop button control.
// Feeds the downstream 7-segment decoder with a 4-bit units and 3-bit tens digit.
module sec_counter_bcd #(
  parameter int unsigned DIV = 50_000_000,
  parameter int unsigned PW  = 26
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       clr,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [PW-1:0] presc;
  logic          btn_edge_c;
  logic          step_c;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn_run;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign btn_edge_c = sync2 & ~prev;
  assign step_c     = (state == RUN) && (presc == PRESC_MAX);

  // Run/stop state, prescaler and BCD digits; clr overrides steps and button edges
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state    <= STOP;
      presc    <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 3'd0;
      running  <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else if (clr) begin
      state    <= STOP;
      presc    <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 3'd0;
      running  <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      running <= (state == RUN);
      tick    <= step_c;
      wrap    <= 1'b0;

      if (btn_edge_c) begin
        state <= (state == RUN) ? STOP : RUN;
      end

      // Prescaler holds in STOP so a pause keeps the sub-second phase
      if (state == RUN) begin
        presc <= step_c ? '0 : presc + PW'(1);
      end

      if (step_c) begin
        if (sec_ones >= 4'd9) begin
          sec_ones <= 4'd0;
        end else begin
          sec_ones <= sec_ones + 4'd1;
        end

        // Out-of-range tens recovers to 0; a real carry comes only from units == 9
        if (sec_tens > 3'd5) begin
          sec_tens <= 3'd0;
        end else if (sec_ones == 4'd9) begin
          if (sec_tens == 3'd5) begin
            sec_tens <= 3'd0;
            wrap     <= 1'b1;
          end else begin
            sec_tens <= sec_tens + 3'd1;
          end
        end
      end
    end
  end

endmodule
